// File: rtl/pair_detect_sched.sv
// Two-requester round-robin scheduler that feeds one 8-bit word at a time into a
// serial detector counting non-overlapping pairs of equal adjacent bits, MSB first.
module pair_detect_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [2:0] count
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {NONE, LAST0, LAST1} hist_t;

  state_t     state_reg;
  hist_t      hist_reg;
  logic [7:0] shreg_reg;
  logic [2:0] bitcnt_reg;
  logic       ptr_reg;
  logic       cur_id_reg;
  logic       sel;

  // With both requesters active the pointer decides; otherwise the lone requester wins.
  always_comb begin
    sel = req[1];
    if (req == 2'b11) sel = ptr_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      hist_reg   <= NONE;
      shreg_reg  <= 8'd0;
      bitcnt_reg <= 3'd0;
      ptr_reg    <= 1'b0;
      cur_id_reg <= 1'b0;
      gnt        <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      count      <= 3'd0;
    end else begin
      gnt  <= 2'b00;
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req != 2'b00) begin
            gnt        <= sel ? 2'b10 : 2'b01;
            shreg_reg  <= sel ? data1 : data0;
            cur_id_reg <= sel;
            ptr_reg    <= ~sel;
            count      <= 3'd0;
            hist_reg   <= NONE;
            bitcnt_reg <= 3'd0;
            busy       <= 1'b1;
            state_reg  <= SHIFT;
          end
        end
        SHIFT: begin
          shreg_reg  <= {shreg_reg[6:0], 1'b0};
          bitcnt_reg <= bitcnt_reg + 3'd1;
          // A matched pair returns history to NONE so the next bit cannot reuse it.
          case (hist_reg)
            NONE:  hist_reg <= shreg_reg[7] ? LAST1 : LAST0;
            LAST0: begin
              if (!shreg_reg[7]) begin
                count    <= count + 3'd1;
                hist_reg <= NONE;
              end else begin
                hist_reg <= LAST1;
              end
            end
            LAST1: begin
              if (shreg_reg[7]) begin
                count    <= count + 3'd1;
                hist_reg <= NONE;
              end else begin
                hist_reg <= LAST0;
              end
            end
            default: hist_reg <= NONE;
          endcase
          if (bitcnt_reg == 3'd7) begin
            done      <= 1'b1;
            done_id   <= cur_id_reg;
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_detect_sched.sv
// Bench for pair_detect_sched: job-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_pair_detect_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] data0, data1;
  logic [1:0] gnt;
  logic       busy, done, done_id;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  pair_detect_sched dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .count(count)
  );

  always #5 clk = ~clk;

  // Pairs found by greedy left-to-right matching over the first n bits (MSB first).
  function automatic int pairs(input logic [7:0] w, input int n);
    int i = 0;
    int c = 0;
    while (i + 1 < n) begin
      if (w[7-i] == w[6-i]) begin
        c++;
        i += 2;
      end else begin
        i += 1;
      end
    end
    return c;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: k counts edges since the grant edge (0 = idle, 1 = grant cycle, 9 = done cycle).
  int         m_k = 0;
  bit         m_ptr = 1'b0;
  bit         m_cur = 1'b0;
  bit         m_last_id = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_word = 8'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_k = 0; m_ptr = 0; m_cur = 0; m_last_id = 0; m_cnt = 0; m_word = 0;
    end else if (m_k == 0) begin
      if (req != 2'b00) begin
        m_cur  = (req == 2'b11) ? m_ptr : req[1];
        m_ptr  = !m_cur;
        m_word = m_cur ? data1 : data0;
        m_cnt  = 0;
        m_k    = 1;
      end
    end else if (m_k < 9) begin
      m_k++;
      m_cnt = pairs(m_word, m_k - 1);
      if (m_k == 9) m_last_id = m_cur;
    end else begin
      m_k = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", gnt, (m_k == 1) ? (m_cur ? 2 : 1) : 0);
      chk("busy", busy, (m_k != 0) ? 1 : 0);
      chk("done", done, (m_k == 9) ? 1 : 0);
      chk("count", count, m_cnt);
      chk("done_id", done_id, m_last_id);
      if (done) $display("job id=%0d count=%0d t=%0t", done_id, count, $time);
    end
  end

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 30 && g == 2'b00; i++) begin
      @(negedge clk);
      g = gnt;
    end
    if (g == 2'b00) chk("gnt_timeout", 0, 1);
  endtask

  task automatic run_job(input string nm, input logic [1:0] r, input logic [7:0] d0,
                         input logic [7:0] d1, input int exp_id, input int exp_cnt);
    bit got = 0;
    req = r; data0 = d0; data1 = d1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        chk({nm, "_id"}, done_id, exp_id);
        chk({nm, "_cnt"}, count, exp_cnt);
      end
    end
    if (!got) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] r;
    int gnt0_seen;

    // Pin the reference function itself.
    chk("model_00", pairs(8'h00, 8), 4);
    chk("model_aa", pairs(8'hAA, 8), 0);
    chk("model_e3", pairs(8'hE3, 8), 3);
    chk("model_cc", pairs(8'hCC, 8), 4);

    rst = 1; req = 0; data0 = 0; data1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_id", done_id, 0);
    rst = 0;
    chk_en = 1;

    run_job("zeros", 2'b01, 8'h00, 8'h00, 0, 4);
    req = 0; repeat (2) @(negedge clk);
    chk("hold_count", count, 4);
    run_job("alt", 2'b10, 8'h00, 8'hAA, 1, 0);
    req = 0; repeat (2) @(negedge clk);
    run_job("nonovl", 2'b01, 8'hE3, 8'h00, 0, 3);
    req = 0; repeat (2) @(negedge clk);

    // Both requesting from a freshly reset pointer.
    rst = 1; @(negedge clk); rst = 0;
    run_job("rr_first", 2'b11, 8'hFF, 8'hCC, 0, 4);
    run_job("rr_second", 2'b11, 8'hFF, 8'hCC, 1, 4);
    req = 0; repeat (2) @(negedge clk);

    // Reset on the 4th shift edge of a job granted to requester 0.
    req = 2'b01; data0 = 8'h5A;
    wait_gnt(g);
    req = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_count", count, 0);
    chk("midrst_gnt", gnt, 0);
    req = 2'b11; data0 = 8'h0F; data1 = 8'h33;
    wait_gnt(g);
    chk("ptr_after_rst", g, 2'b01);
    req = 0;
    repeat (10) @(negedge clk);
    run_job("after_rst", 2'b10, 8'h00, 8'h33, 1, 4);
    req = 0; repeat (2) @(negedge clk);

    // Requester 0 pulses while busy and withdraws before IDLE.
    req = 2'b10; data1 = 8'h96;
    wait_gnt(g);
    req = 0;
    gnt0_seen = 0;
    repeat (2) @(negedge clk);
    req = 2'b01; data0 = 8'h11;
    repeat (2) @(negedge clk);
    req = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (gnt[0]) gnt0_seen++;
    end
    chk("withdraw_no_gnt0", gnt0_seen, 0);

    // Random traffic; a word only changes while its request is low.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      r = req;
      for (int i = 0; i < 2; i++) begin
        if (r[i]) begin
          if (gnt[i] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0)) r[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          r[i] = 1'b1;
          if (i == 0) data0 = 8'($urandom);
          else        data1 = 8'($urandom);
        end
      end
      req = r;
    end
    req = 0; rst = 0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
